// File: rtl/tracer_pkg.sv
// -----------------------------------------------------------------------------
// tracer_pkg
// Shared definitions for the trace scheduler slice:
//   - state_e         : scheduler FSM states
//   - CELL_SIZE       : edge length of one trace cell in pixels
//   - DEFAULT_GRID_*  : default grid size (640x480 screen in 8x8 cells)
//   - *_W             : port widths for coordinates, cell address, colour, perf
//   - cell_centre()   : cell column/row -> pixel coordinate of the cell centre
// -----------------------------------------------------------------------------
package tracer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int CELL_SIZE               = 8;
  localparam int CELL_HALF               = CELL_SIZE / 2;
  localparam int DEFAULT_GRID_W          = 80;
  localparam int DEFAULT_GRID_H          = 60;
  localparam int DEFAULT_MAX_OUTSTANDING = 4;

  localparam int COORD_W = 10;  // pixel coordinate and cell col/row width
  localparam int ADDR_W  = 13;  // cell buffer address width
  localparam int RGB_W   = 6;   // {R[1:0],G[1:0],B[1:0]}
  localparam int OUT_W   = 4;   // outstanding counter, holds 0..8
  localparam int PERF_W  = 24;

  function automatic logic [COORD_W-1:0] cell_centre(input logic [COORD_W-1:0] idx);
    return COORD_W'(32'(idx) * CELL_SIZE + CELL_HALF);
  endfunction

endpackage

// File: rtl/raster_walker.sv
// -----------------------------------------------------------------------------
// raster_walker
// Column/row counter walking a GRID_W x GRID_H grid in raster order.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : synchronous return to (0,0); wins over advance
//   advance    : step one cell (col wraps at GRID_W-1, then row steps)
//   col, row   : current cell
//   last       : current cell is the final cell of the grid
// -----------------------------------------------------------------------------
module raster_walker
  import tracer_pkg::*;
#(
  parameter int GRID_W = DEFAULT_GRID_W,
  parameter int GRID_H = DEFAULT_GRID_H
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               advance,
  output logic [COORD_W-1:0] col,
  output logic [COORD_W-1:0] row,
  output logic               last
);

  logic [COORD_W-1:0] col_q, col_d;
  logic [COORD_W-1:0] row_q, row_d;
  logic               col_end;
  logic               row_end;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    col_end = (col_q == COORD_W'(GRID_W - 1));
    row_end = (row_q == COORD_W'(GRID_H - 1));
    col_d   = col_q;
    row_d   = row_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (advance) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + COORD_W'(1);
      end else begin
        col_d = col_q + COORD_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign last = col_end && row_end;

endmodule

// File: rtl/trace_scheduler.sv
// -----------------------------------------------------------------------------
// trace_scheduler
// Issues one tracing job per grid cell in raster order to a tracer core, keeps
// at most MAX_OUTSTANDING jobs in flight, and writes the in-order results into
// a cell buffer.
//
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   frame_start, enable : new-frame pulse, accepted in IDLE only while enable=1
//   job_valid/job_ready : job handshake; job_x/job_y = pixel centre of the cell
//   res_valid, res_rgb  : in-order result pulse and colour
//   wr_en/wr_addr/wr_data : cell buffer write port (addr = row*GRID_W+col)
//   busy                : frame in progress (ISSUE or DRAIN)
//   frame_done          : one-cycle pulse after the last result is written
//   overrun             : one-cycle pulse when a frame_start is dropped
//   perf_cycles         : only with TRACE_SCHED_PERF_EN defined; cycles from
//                         ISSUE entry to frame end, saturating, latched in DONE
// -----------------------------------------------------------------------------
module trace_scheduler
  import tracer_pkg::*;
#(
  parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
  parameter int GRID_W          = DEFAULT_GRID_W,
  parameter int GRID_H          = DEFAULT_GRID_H
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               enable,
  output logic               job_valid,
  input  logic               job_ready,
  output logic [COORD_W-1:0] job_x,
  output logic [COORD_W-1:0] job_y,
  input  logic               res_valid,
  input  logic [RGB_W-1:0]   res_rgb,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [RGB_W-1:0]   wr_data,
  output logic               busy,
  output logic               frame_done,
  output logic               overrun
`ifdef TRACE_SCHED_PERF_EN
  ,
  output logic [PERF_W-1:0]  perf_cycles
`endif
);

  state_e             state_q, state_d;
  logic [OUT_W-1:0]   out_q, out_d;

  logic               start_frame;
  logic               handshake;
  logic               res_accept;

  logic [COORD_W-1:0] issue_col, issue_row;
  logic               issue_last;
  logic [COORD_W-1:0] wr_col, wr_row;
  logic               wr_last_unused;

  raster_walker #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H)
  ) u_issue_walker (
    .clk     (clk),
    .reset   (reset),
    .clear   (start_frame),
    .advance (handshake),
    .col     (issue_col),
    .row     (issue_row),
    .last    (issue_last)
  );

  raster_walker #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H)
  ) u_write_walker (
    .clk     (clk),
    .reset   (reset),
    .clear   (start_frame),
    .advance (res_accept),
    .col     (wr_col),
    .row     (wr_row),
    .last    (wr_last_unused)
  );

  always_comb begin
    start_frame = (state_q == ST_IDLE) && frame_start && enable;
    // A result with nothing in flight is stale (e.g. from before a reset).
    res_accept  = res_valid && (out_q != '0);
    // A result in the same cycle frees a slot, so a full window may still issue.
    job_valid   = (state_q == ST_ISSUE) &&
                  ((out_q < OUT_W'(MAX_OUTSTANDING)) || res_valid);
    handshake   = job_valid && job_ready;

    out_d = out_q;
    if (handshake && !res_accept) begin
      out_d = out_q + OUT_W'(1);
    end else if (!handshake && res_accept) begin
      out_d = out_q - OUT_W'(1);
    end

    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_frame) state_d = ST_ISSUE;
      ST_ISSUE: if (handshake && issue_last) state_d = ST_DRAIN;
      ST_DRAIN: if (out_q == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: reset clears only control state; there is no memory in this block,
  // and the datapath outputs are gated by their strobes so they read 0 in reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  // Coordinates and write data are zeroed when not strobed; while a job is
  // stalled the issue counters do not move, so job_x/job_y stay stable.
  assign job_x      = job_valid ? cell_centre(issue_col) : '0;
  assign job_y      = job_valid ? cell_centre(issue_row) : '0;
  assign wr_en      = res_accept;
  assign wr_addr    = res_accept ?
                      (ADDR_W'(wr_row) * ADDR_W'(GRID_W) + ADDR_W'(wr_col)) : '0;
  assign wr_data    = res_accept ? res_rgb : '0;
  assign busy       = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign frame_done = (state_q == ST_DONE);
  assign overrun    = frame_start && (state_q != ST_IDLE);

`ifdef TRACE_SCHED_PERF_EN
  logic [PERF_W-1:0] perf_cnt_q, perf_cnt_d;
  logic [PERF_W-1:0] perf_cycles_q, perf_cycles_d;

  always_comb begin
    perf_cnt_d    = perf_cnt_q;
    perf_cycles_d = perf_cycles_q;
    if (start_frame) begin
      perf_cnt_d = '0;
    end else if (busy && (perf_cnt_q != '1)) begin
      perf_cnt_d = perf_cnt_q + PERF_W'(1);
    end
    if (state_q == ST_DONE) begin
      perf_cycles_d = perf_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cnt_q    <= '0;
      perf_cycles_q <= '0;
    end else begin
      perf_cnt_q    <= perf_cnt_d;
      perf_cycles_q <= perf_cycles_d;
    end
  end

  assign perf_cycles = perf_cycles_q;
`endif

endmodule
